beep_sequencer: RTL and testbench
=================================

// Module: beep_sequencer
// PURPOSE
//  Multi-event audible alarm generator; parametrised successor of the single-tone lock buzzer.
//  Each of NUM_EVT request lines selects its own tone period, burst length, gap length and repeat count.
//  Requests are priority-arbitrated and can pre-empt lower-priority sequences.
//  Sits between the control FSMs (lock/timeout/keypad) and the piezo pin.
// PARAMETERS
//  NUM_EVT   2                               number of event channels (1..8); higher index = higher priority
//  TONE_PER  {24'd12000,24'd12000}           packed, 24b per event [i*24+:24]: tone period in clk cycles (even, >=2)
//  ON_CYC    {28'd6000000,28'd12000000}      packed, 28b per event: burst length in clk cycles (>=1)
//  OFF_CYC   {28'd6000000,28'd0}             packed, 28b per event: gap between bursts in clk cycles
//  REPEAT    {8'd3,8'd1}                     packed, 8b per event: number of bursts (0 treated as 1)
// PORTS
//  clk       in   1        system clock (12 MHz on board)
//  rst       in   1        synchronous reset, active-high
//  evt_req   in   NUM_EVT  one-cycle request pulses, bit i = event i
//  cancel    in   1        abort current sequence
//  mute      in   1        gates beep_out only; sequencing continues
//  beep_out  out  1        square-wave drive to buzzer
//  busy      out  1        high in ON or GAP state
//  active_id out  3        index of running event (valid while busy)
//  done      out  1        one-cycle pulse on natural completion of a sequence
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state IDLE; beep_out=0, busy=0, active_id=0, done=0; all counters 0.
//  States: IDLE, ON, GAP. Counters: tone_cnt (24b), dur_cnt (28b), rep_left (8b).
//  Arbitration: highest set bit of evt_req wins that cycle (k).
//   IDLE: any req -> ON with event k next cycle.
//   ON/GAP: accept k only if k >= active_id (equal restarts same event); lower k ignored, not queued.
//   Accept: latch active_id=k, rep_left=max(REPEAT[k],1), dur_cnt=0, tone_cnt=0; done not pulsed for pre-empted run.
//  Latency: req sampled at edge N -> busy=1 from edge N+1; first tone half (low) starts at N+1.
//  ON: tone_cnt counts 0..TONE_PER-1 and wraps; beep_out = (tone_cnt >= TONE_PER/2) & ~mute.
//   dur_cnt counts 0..ON_CYC-1; ON lasts exactly ON_CYC cycles.
//   At dur_cnt=ON_CYC-1: rep_left-1 ==0 -> IDLE with done=1 next cycle; else rep_left--, dur_cnt=0,
//   -> GAP if OFF_CYC>0, otherwise directly back to ON (tone_cnt restarts at 0).
//  GAP: beep_out=0, tone_cnt held 0; lasts exactly OFF_CYC cycles then -> ON with dur_cnt=0.
//  IDLE: beep_out=0, busy=0, tone_cnt=dur_cnt=0.
//  cancel=1: -> IDLE next cycle, no done; cancel beats evt_req in the same cycle (request dropped).
//  done: asserted exactly one cycle, coincident with first IDLE cycle; never with busy=1.
//  rst mid-sequence: immediate return to reset values on that edge; no done.
//  All counter compares use full declared widths; no counter wraps except tone_cnt at TONE_PER-1.
// TESTING  (bench overrides: TONE_PER=8/8, ON_CYC=20/16, OFF_CYC=0/10, REPEAT=1/3)
//  1 evt_req=01 one pulse -> busy 20 cycles, beep_out low 4/high 4 from cycle 1, done at cycle 21, 0 after.
//  2 evt_req=10 -> 3 bursts of 16 with 10-cycle gaps (beep_out=0 in gaps), busy=68 cycles, one done pulse.
//  3 event0 running, evt_req=10 at cycle 5 -> active_id=1 next cycle, tone_cnt restarts, no done for event0.
//  4 event1 running, evt_req=01 -> ignored; event1 completes unchanged, single done.
//  5 cancel and evt_req=10 same cycle while event0 busy -> IDLE next cycle, busy=0, no done, no new run.
//  6 mute=1 throughout event1 -> beep_out constant 0, busy/done timing identical to test 2; rst mid-GAP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/beep_sequencer.sv
// Priority-arbitrated multi-event buzzer sequencer: each event plays REPEAT bursts of a
// square tone, separated by optional silent gaps, and higher events may pre-empt lower ones.
module beep_sequencer #(
  parameter int                    NUM_EVT  = 2,
  parameter logic [NUM_EVT*24-1:0] TONE_PER = {24'd12000, 24'd12000},
  parameter logic [NUM_EVT*28-1:0] ON_CYC   = {28'd6000000, 28'd12000000},
  parameter logic [NUM_EVT*28-1:0] OFF_CYC  = {28'd6000000, 28'd0},
  parameter logic [NUM_EVT*8-1:0]  REPEAT   = {8'd3, 8'd1}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt_req,
  input  logic               cancel,
  input  logic               mute,
  output logic               beep_out,
  output logic               busy,
  output logic [2:0]         active_id,
  output logic               done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

  state_t      state_reg, state_next;
  logic [23:0] tone_reg, tone_next;
  logic [27:0] dur_reg, dur_next;
  logic [7:0]  rep_reg, rep_next;
  logic [2:0]  id_reg, id_next;
  logic        done_reg, done_next;

  // Per-event tables padded to 8 entries so the 3-bit event id indexes them directly.
  logic [23:0] tone_tab [8];
  logic [27:0] on_tab   [8];
  logic [27:0] off_tab  [8];
  logic [7:0]  rep_tab  [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_tab
    if (gi < NUM_EVT) begin : g_used
      assign tone_tab[gi] = TONE_PER[gi*24 +: 24];
      assign on_tab[gi]   = ON_CYC[gi*28 +: 28];
      assign off_tab[gi]  = OFF_CYC[gi*28 +: 28];
      assign rep_tab[gi]  = (REPEAT[gi*8 +: 8] == 8'd0) ? 8'd1 : REPEAT[gi*8 +: 8];
    end else begin : g_unused
      assign tone_tab[gi] = 24'd2;
      assign on_tab[gi]   = 28'd1;
      assign off_tab[gi]  = 28'd0;
      assign rep_tab[gi]  = 8'd1;
    end
  end

  logic [2:0]  req_id;
  logic        req_any;
  logic        accept;
  logic [23:0] cur_tone;
  logic [27:0] cur_on;
  logic [27:0] cur_off;

  always_comb begin
    req_id = 3'd0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (evt_req[i]) req_id = 3'(i);
    end
  end

  assign req_any  = |evt_req;
  assign accept   = req_any && ((state_reg == ST_IDLE) || (req_id >= id_reg));
  assign cur_tone = tone_tab[id_reg];
  assign cur_on   = on_tab[id_reg];
  assign cur_off  = off_tab[id_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      tone_reg  <= '0;
      dur_reg   <= '0;
      rep_reg   <= '0;
      id_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tone_reg  <= tone_next;
      dur_reg   <= dur_next;
      rep_reg   <= rep_next;
      id_reg    <= id_next;
      done_reg  <= done_next;
    end
  end

  // Cancel outranks any request; an accepted request outranks the running sequence's own progress.
  always_comb begin
    state_next = state_reg;
    tone_next  = tone_reg;
    dur_next   = dur_reg;
    rep_next   = rep_reg;
    id_next    = id_reg;
    done_next  = 1'b0;
    if (cancel) begin
      state_next = ST_IDLE;
      tone_next  = '0;
      dur_next   = '0;
      rep_next   = '0;
    end else if (accept) begin
      state_next = ST_ON;
      tone_next  = '0;
      dur_next   = '0;
      rep_next   = rep_tab[req_id];
      id_next    = req_id;
    end else begin
      case (state_reg)
        ST_ON: begin
          tone_next = (tone_reg == cur_tone - 24'd1) ? '0 : tone_reg + 24'd1;
          if (dur_reg == cur_on - 28'd1) begin
            dur_next  = '0;
            tone_next = '0;
            if (rep_reg - 8'd1 == 8'd0) begin
              state_next = ST_IDLE;
              rep_next   = '0;
              done_next  = 1'b1;
            end else begin
              rep_next   = rep_reg - 8'd1;
              state_next = (cur_off != 28'd0) ? ST_GAP : ST_ON;
            end
          end else begin
            dur_next = dur_reg + 28'd1;
          end
        end
        ST_GAP: begin
          tone_next = '0;
          if (dur_reg == cur_off - 28'd1) begin
            state_next = ST_ON;
            dur_next   = '0;
          end else begin
            dur_next = dur_reg + 28'd1;
          end
        end
        default: begin
          tone_next = '0;
          dur_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE);
    beep_out  = (state_reg == ST_ON) && (tone_reg >= (cur_tone >> 1)) && !mute;
    active_id = id_reg;
    done      = done_reg;
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Randomised and scenario-driven bench for beep_sequencer, scored against an elapsed-time
// model: each running event's outputs are derived from time since its start.
module tb_beep_sequencer;

  localparam int NUM_EVT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_EVT-1:0] evt_req;
  logic               cancel;
  logic               mute;
  logic               beep_out;
  logic               busy;
  logic [2:0]         active_id;
  logic               done;

  always #5 clk = ~clk;

  beep_sequencer #(
    .NUM_EVT  (NUM_EVT),
    .TONE_PER ({24'd8, 24'd8}),
    .ON_CYC   ({28'd16, 28'd20}),
    .OFF_CYC  ({28'd10, 28'd0}),
    .REPEAT   ({8'd3, 8'd1})
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_req   (evt_req),
    .cancel    (cancel),
    .mute      (mute),
    .beep_out  (beep_out),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  int tone_m [2] = '{8, 8};
  int on_m   [2] = '{20, 16};
  int off_m  [2] = '{0, 10};
  int rep_m  [2] = '{1, 3};

  int n_cmp = 0;
  int n_mis = 0;

  bit m_run;
  bit m_done;
  int m_id;
  int m_el;

  int busy_cnt;
  int done_cnt;
  int beep_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int total_len(input int e);
    int r;
    r = (rep_m[e] < 1) ? 1 : rep_m[e];
    return r * on_m[e] + (r - 1) * off_m[e];
  endfunction

  // One clock edge: drive inputs, advance the model, compare every output.
  task automatic step(input logic [1:0] req, input logic c, input logic m, input logic r);
    int k;
    int ph;
    logic exp_beep;
    evt_req = req;
    cancel  = c;
    mute    = m;
    rst     = r;
    @(posedge clk);
    #1;
    k = req[1] ? 1 : 0;
    m_done = 1'b0;
    if (r) begin
      m_run = 1'b0;
      m_id  = 0;
      m_el  = 0;
    end else if (c) begin
      m_run = 1'b0;
    end else if (req != 2'b00 && (!m_run || k >= m_id)) begin
      m_run = 1'b1;
      m_id  = k;
      m_el  = 0;
    end else if (m_run) begin
      m_el++;
      if (m_el == total_len(m_id)) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
    exp_beep = 1'b0;
    if (m_run) begin
      ph = m_el % (on_m[m_id] + off_m[m_id]);
      if (ph < on_m[m_id] && (ph % tone_m[m_id]) >= tone_m[m_id] / 2 && !m) exp_beep = 1'b1;
    end
    check_val("busy", 32'(busy), 32'(m_run));
    check_val("done", 32'(done), 32'(m_done));
    check_val("beep", 32'(beep_out), 32'(exp_beep));
    if (m_run) check_val("active_id", 32'(active_id), 32'(m_id));
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    beep_cnt += int'(beep_out);
  endtask

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, m, 1'b0);
  endtask

  task automatic clr_cnt();
    busy_cnt = 0;
    done_cnt = 0;
    beep_cnt = 0;
  endtask

  initial begin
    evt_req = '0;
    cancel  = 1'b0;
    mute    = 1'b0;
    rst     = 1'b1;
    m_run   = 1'b0;
    m_done  = 1'b0;
    m_id    = 0;
    m_el    = 0;
    clr_cnt();

    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    check_val("reset_id", 32'(active_id), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    idle(2, 1'b0);

    // Event 0 single burst.
    clr_cnt();
    step(2'b01, 1'b0, 1'b0, 1'b0);
    idle(25, 1'b0);
    check_val("t1_busy_len", 32'(busy_cnt), 32'd20);
    check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t1_beep_cnt", 32'(beep_cnt), 32'd8);

    // Event 1: three bursts with gaps.
    clr_cnt();
    step(2'b10, 1'b0, 1'b0, 1'b0);
    idle(75, 1'b0);
    check_val("t2_busy_len", 32'(busy_cnt), 32'd68);
    check_val("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Event 1 pre-empts event 0.
    clr_cnt();
    step(2'b01, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    check_val("t3_id", 32'(active_id), 32'd1);
    idle(75, 1'b0);
    check_val("t3_busy_len", 32'(busy_cnt), 32'd73);
    check_val("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Lower-priority request while event 1 runs is ignored.
    clr_cnt();
    step(2'b10, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    idle(75, 1'b0);
    check_val("t4_busy_len", 32'(busy_cnt), 32'd68);
    check_val("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Cancel wins over a simultaneous request.
    clr_cnt();
    step(2'b01, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check_val("t5_busy", 32'(busy), 32'd0);
    idle(5, 1'b0);
    check_val("t5_busy_len", 32'(busy_cnt), 32'd4);
    check_val("t5_done_cnt", 32'(done_cnt), 32'd0);

    // Muted event 1, then reset during a gap.
    clr_cnt();
    step(2'b10, 1'b0, 1'b1, 1'b0);
    idle(75, 1'b1);
    check_val("t6_beep_cnt", 32'(beep_cnt), 32'd0);
    check_val("t6_busy_len", 32'(busy_cnt), 32'd68);
    check_val("t6_done_cnt", 32'(done_cnt), 32'd1);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_id", 32'(active_id), 32'd0);
    check_val("t6_rst_beep", 32'(beep_out), 32'd0);
    check_val("t6_rst_done", 32'(done), 32'd0);
    idle(3, 1'b0);

    // Random traffic: sparse requests, occasional cancel/reset, toggling mute.
    begin
      logic m_rand;
      m_rand = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        logic [1:0] rq;
        logic       cc;
        logic       rr;
        rq = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        cc = ($urandom_range(0, 149) == 0);
        rr = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 39) == 0) m_rand = ~m_rand;
        step(rq, cc, m_rand, rr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
